// File: rtl/ev20_fetch_pkg.sv
// Shared types and constants for the ev20 instruction fetch unit.
// The optional fetch timeout is enabled with EV20_FETCH_TIMEOUT_EN.
package ev20_fetch_pkg;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 16;
    localparam int TIMEOUT_LIMIT = 255;
    localparam int WAIT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADV  = 2'd2
    } state_e;
endpackage

// File: rtl/ev20_fetch_unit_if.sv
// Fetch unit bus: PC counter control, program-memory read port and decoder handshake.
// Master is the fetch unit; slave is the surrounding core/memory/decoder.
interface ev20_fetch_unit_if #(
    parameter int ADDR_W = ev20_fetch_pkg::DEF_ADDR_W,
    parameter int DATA_W = ev20_fetch_pkg::DEF_DATA_W
) ();
    logic [ADDR_W-1:0] pc;
    logic              pc_adv;
    logic              branch;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;

    modport master (
        input  pc, branch, mem_ack, mem_rdata, ins_ready,
        output pc_adv, mem_req, mem_addr, ins_valid, ins_data, ins_pc
    );
    modport slave (
        output pc, branch, mem_ack, mem_rdata, ins_ready,
        input  pc_adv, mem_req, mem_addr, ins_valid, ins_data, ins_pc
    );
endinterface

// File: rtl/ev20_fetch_fifo.sv
// Two-entry instruction buffer holding {pc, word}; flush beats push and pop.
module ev20_fetch_fifo #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         res,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic         o_valid,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [1:0][W-1:0] r_mem;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_mem    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/ev20_fetch_unit.sv
// Instruction fetch FSM (IDLE -> REQ -> ADV) feeding a 2-entry buffer toward the decoder.
// EV20_FETCH_TIMEOUT_EN adds a REQ wait counter and a sticky fetch_err output.
module ev20_fetch_unit
    import ev20_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                res,
    ev20_fetch_unit_if.master   bus
`ifdef EV20_FETCH_TIMEOUT_EN
    ,
    output logic                fetch_err
`endif
);
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    state_e                     r_state;
    state_e                     w_next;
    logic [ADDR_W-1:0]          r_mem_addr;
    logic                       r_discard;
    logic                       w_issue;
    logic                       w_push;
    logic                       w_done;
    logic                       w_set_discard;
    logic                       w_timeout;
    logic                       w_fifo_valid;
    logic [ADDR_W+DATA_W-1:0]   w_head;
    logic [1:0]                 w_count;

`ifdef EV20_FETCH_TIMEOUT_EN
    logic [WAIT_W-1:0]          r_wait;
    logic                       r_fetch_err;

    assign w_timeout = (r_state == ST_REQ) && !bus.mem_ack &&
                       (r_wait == WAIT_W'(TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_wait      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_issue)
                r_wait <= '0;
            else if (r_state == ST_REQ)
                r_wait <= r_wait + 1'b1;
            if (w_timeout)
                r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_issue       = 1'b0;
        w_push        = 1'b0;
        w_done        = 1'b0;
        w_set_discard = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.branch && (w_count < FULL_CNT)) begin
                    w_issue = 1'b1;
                    w_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                // A redirect seen now or earlier turns the pending read into a dead one.
                if (bus.mem_ack) begin
                    w_done = 1'b1;
                    if (r_discard || bus.branch) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_push = 1'b1;
                        w_next = ST_ADV;
                    end
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (bus.branch) begin
                    w_set_discard = 1'b1;
                end
            end
            ST_ADV:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_mem_addr <= '0;
            r_discard  <= 1'b0;
        end else begin
            if (w_issue)
                r_mem_addr <= bus.pc;
            if (w_done)
                r_discard <= 1'b0;
            else if (w_set_discard)
                r_discard <= 1'b1;
        end
    end

    assign bus.mem_req  = (r_state == ST_REQ);
    assign bus.mem_addr = r_mem_addr;
    assign bus.pc_adv   = (r_state == ST_ADV);

    ev20_fetch_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
        .clk     (clk),
        .res     (res),
        .i_push  (w_push),
        .i_pop   (bus.ins_valid && bus.ins_ready),
        .i_flush (bus.branch),
        .i_din   ({r_mem_addr, bus.mem_rdata}),
        .o_valid (w_fifo_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.ins_valid = w_fifo_valid;
    assign bus.ins_pc    = w_fifo_valid ? w_head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign bus.ins_data  = w_fifo_valid ? w_head[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_ev20_fetch_unit.sv
// Directed bench for ev20_fetch_unit: PC counter model, programmable-latency memory responder.
// Timeout scenario runs only when EV20_FETCH_TIMEOUT_EN is defined.
module tb_ev20_fetch_unit;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        auto_ack = 1'b0;
    logic        late_ack = 1'b0;
    logic [10:0] br_target = '0;
    int          total = 0;
    int          bad = 0;
`ifdef EV20_FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    ev20_fetch_unit_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    ev20_fetch_unit #(.ADDR_W(11), .DATA_W(16), .DEPTH(2)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
`ifdef EV20_FETCH_TIMEOUT_EN
        ,
        .fetch_err (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    // PC counter: preload has precedence over increment
    always @(posedge clk or posedge res) begin
        if (res)             bus.pc <= '0;
        else if (bus.branch) bus.pc <= br_target;
        else if (bus.pc_adv) bus.pc <= bus.pc + 11'd1;
    end

    always @(negedge clk) begin
        if (ack_en && bus.mem_req) begin
            if (wcnt >= ack_delay) begin
                auto_ack = 1'b1;
                wcnt = 0;
            end else begin
                auto_ack = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            auto_ack = 1'b0;
            wcnt = 0;
        end
    end

    assign bus.mem_ack   = auto_ack | late_ack;
    assign bus.mem_rdata = 16'hA000 | {5'b0, bus.mem_addr};

    task automatic do_reset();
        res = 1'b1; bus.branch = 1'b0; bus.ins_ready = 1'b0;
        late_ack = 1'b0; ack_en = 1'b1; ack_delay = 0; br_target = '0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; bus.branch = 1'b0; bus.ins_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        total++; if (bus.mem_addr !== 11'h000) begin bad++; $display("FAIL rst_mem_addr: got %h want 000", bus.mem_addr); end
        total++; if (bus.pc_adv !== 1'b0) begin bad++; $display("FAIL rst_pc_adv: got %b want 0", bus.pc_adv); end
        total++; if (bus.ins_valid !== 1'b0) begin bad++; $display("FAIL rst_ins_valid: got %b want 0", bus.ins_valid); end
        total++; if (bus.ins_data !== 16'h0000) begin bad++; $display("FAIL rst_ins_data: got %h want 0000", bus.ins_data); end
        total++; if (bus.ins_pc !== 11'h000) begin bad++; $display("FAIL rst_ins_pc: got %h want 000", bus.ins_pc); end
`ifdef EV20_FETCH_TIMEOUT_EN
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        bus.ins_ready = 1'b1;
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 11'h000}) begin bad++; $display("FAIL basic_req0: got req=%b addr=%h want 1/000", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        total++; if ({bus.pc_adv, bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 1'b1, 11'h000, 16'hA000}) begin bad++; $display("FAIL basic_adv0: got adv=%b v=%b pc=%h d=%h want 1/1/000/a000", bus.pc_adv, bus.ins_valid, bus.ins_pc, bus.ins_data); end
        @(negedge clk);
        total++; if ({bus.pc_adv, bus.ins_valid, bus.mem_req} !== 3'b000) begin bad++; $display("FAIL basic_idle: got adv=%b v=%b req=%b want 0/0/0", bus.pc_adv, bus.ins_valid, bus.mem_req); end
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 11'h001}) begin bad++; $display("FAIL basic_req1: got req=%b addr=%h want 1/001", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        total++; if ({bus.pc_adv, bus.ins_valid, bus.ins_pc} !== {1'b1, 1'b1, 11'h001}) begin bad++; $display("FAIL basic_adv1: got adv=%b v=%b pc=%h want 1/1/001", bus.pc_adv, bus.ins_valid, bus.ins_pc); end
        @(negedge clk);
        total++; if (bus.pc_adv !== 1'b0) begin bad++; $display("FAIL basic_pulse: got adv=%b want 0", bus.pc_adv); end
    endtask

    task automatic test_full();
        logic req_seen;
        do_reset();
        repeat (5) @(negedge clk);
        req_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0) req_seen = 1'b1;
        end
        total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL full_no_req: got req_seen=%b want 0", req_seen); end
        total++; if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 11'h000, 16'hA000}) begin bad++; $display("FAIL full_head0: got v=%b pc=%h d=%h want 1/000/a000", bus.ins_valid, bus.ins_pc, bus.ins_data); end
        bus.ins_ready = 1'b1;
        @(negedge clk);
        total++; if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 11'h001, 16'hA001}) begin bad++; $display("FAIL full_head1: got v=%b pc=%h d=%h want 1/001/a001", bus.ins_valid, bus.ins_pc, bus.ins_data); end
        @(negedge clk);
        total++; if ({bus.ins_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 11'h002}) begin bad++; $display("FAIL full_resume: got v=%b req=%b addr=%h want 0/1/002", bus.ins_valid, bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_branch_req();
        logic stale;
        logic found;
        int   held;
        do_reset();
        bus.ins_ready = 1'b1;
        ack_delay = 4;
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 11'h000}) begin bad++; $display("FAIL brq_req0: got req=%b addr=%h want 1/000", bus.mem_req, bus.mem_addr); end
        br_target = 11'h2A0;
        bus.branch = 1'b1;
        stale = 1'b0; found = 1'b0; held = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (i == 0) bus.branch = 1'b0;
            if (bus.mem_req && bus.mem_addr == 11'h2A0) found = 1'b1;
            else begin
                if (bus.ins_valid !== 1'b0 || bus.pc_adv !== 1'b0) stale = 1'b1;
                if (bus.mem_req === 1'b1 && bus.mem_addr == 11'h000) held++;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL brq_new_addr: got found=%b addr=%h want 1/2a0", found, bus.mem_addr); end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL brq_stale: got stale=%b want 0", stale); end
        total++; if (held != 4) begin bad++; $display("FAIL brq_hold: got %0d cycles want 4", held); end
    endtask

    task automatic test_branch_ack();
        do_reset();
        repeat (3) @(negedge clk);
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr, bus.ins_valid} !== {1'b1, 11'h001, 1'b1}) begin bad++; $display("FAIL bra_setup: got req=%b addr=%h v=%b want 1/001/1", bus.mem_req, bus.mem_addr, bus.ins_valid); end
        br_target = 11'h155;
        bus.branch = 1'b1;
        bus.ins_ready = 1'b1;
        @(negedge clk);
        bus.branch = 1'b0;
        bus.ins_ready = 1'b0;
        total++; if ({bus.ins_valid, bus.pc_adv} !== 2'b00) begin bad++; $display("FAIL bra_flush: got v=%b adv=%b want 0/0", bus.ins_valid, bus.pc_adv); end
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr, bus.pc_adv} !== {1'b1, 11'h155, 1'b0}) begin bad++; $display("FAIL bra_req: got req=%b addr=%h adv=%b want 1/155/0", bus.mem_req, bus.mem_addr, bus.pc_adv); end
        @(negedge clk);
        total++; if ({bus.pc_adv, bus.ins_valid, bus.ins_pc} !== {1'b1, 1'b1, 11'h155}) begin bad++; $display("FAIL bra_adv: got adv=%b v=%b pc=%h want 1/1/155", bus.pc_adv, bus.ins_valid, bus.ins_pc); end
    endtask

    task automatic test_branch_adv();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({bus.pc_adv, bus.ins_valid} !== 2'b11) begin bad++; $display("FAIL bradv_adv: got adv=%b v=%b want 1/1", bus.pc_adv, bus.ins_valid); end
        br_target = 11'h07F;
        bus.branch = 1'b1;
        @(negedge clk);
        total++; if ({bus.ins_valid, bus.pc_adv, bus.mem_req} !== 3'b000) begin bad++; $display("FAIL bradv_flush: got v=%b adv=%b req=%b want 0/0/0", bus.ins_valid, bus.pc_adv, bus.mem_req); end
        @(negedge clk);
        bus.branch = 1'b0;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL bradv_block: got req=%b want 0", bus.mem_req); end
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 11'h07F}) begin bad++; $display("FAIL bradv_req: got req=%b addr=%h want 1/07f", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        ack_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr, bus.ins_valid} !== {1'b1, 11'h001, 1'b1}) begin bad++; $display("FAIL rmid_setup: got req=%b addr=%h v=%b want 1/001/1", bus.mem_req, bus.mem_addr, bus.ins_valid); end
        #2 res = 1'b1;
        #1;
        total++; if ({bus.mem_req, bus.mem_addr, bus.pc_adv, bus.ins_valid, bus.ins_pc, bus.ins_data} !== 30'd0) begin bad++; $display("FAIL rmid_async: got req=%b addr=%h adv=%b v=%b pc=%h d=%h want all 0", bus.mem_req, bus.mem_addr, bus.pc_adv, bus.ins_valid, bus.ins_pc, bus.ins_data); end
        @(negedge clk);
        res = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        total++; if ({bus.mem_req, bus.mem_addr, bus.ins_valid, bus.pc_adv} !== {1'b1, 11'h000, 1'b0, 1'b0}) begin bad++; $display("FAIL rmid_late: got req=%b addr=%h v=%b adv=%b want 1/000/0/0", bus.mem_req, bus.mem_addr, bus.ins_valid, bus.pc_adv); end
        @(negedge clk);
        total++; if ({bus.mem_req, bus.ins_valid, bus.pc_adv} !== 3'b100) begin bad++; $display("FAIL rmid_wait: got req=%b v=%b adv=%b want 1/0/0", bus.mem_req, bus.ins_valid, bus.pc_adv); end
    endtask

`ifdef EV20_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        do_reset();
        ack_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.mem_req) cnt++;
            else if (cnt > 0) break;
        end
        total++; if (cnt != 255) begin bad++; $display("FAIL to_cycles: got %0d want 255", cnt); end
        total++; if ({fetch_err, bus.mem_req, bus.pc_adv, bus.ins_valid} !== 4'b1000) begin bad++; $display("FAIL to_state: got err=%b req=%b adv=%b v=%b want 1/0/0/0", fetch_err, bus.mem_req, bus.pc_adv, bus.ins_valid); end
        ack_en = 1'b1;
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 11'h000}) begin bad++; $display("FAIL to_resume: got req=%b addr=%h want 1/000", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        total++; if ({bus.ins_valid, bus.ins_pc, fetch_err} !== {1'b1, 11'h000, 1'b1}) begin bad++; $display("FAIL to_push: got v=%b pc=%h err=%b want 1/000/1", bus.ins_valid, bus.ins_pc, fetch_err); end
    endtask
`endif

    initial begin
        bus.branch = 1'b0;
        bus.ins_ready = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_branch_req();
        test_branch_ack();
        test_branch_adv();
        test_reset_mid();
`ifdef EV20_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ev20_fetch_unit.md
EV20_FETCH_UNIT -- requirements
Module: ev20_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 11: program-counter and program-memory address width.
REQ-002 Parameter DATA_W, 16: instruction word width.
REQ-003 Parameter DEPTH, 2: instruction buffer entries; fixed at 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 res  in  1  asynchronous, active-high reset.
REQ-006 pc  in  ADDR_W  current value from the PC counter.
REQ-007 pc_adv  out  1  one-cycle pulse; gates the PC counter increment.
REQ-008 branch  in  1  redirect/flush request; the PC counter preloads on the same edge.
REQ-009 mem_req  out  1  program-memory read request.
REQ-010 mem_addr  out  ADDR_W  read address; stable while mem_req=1.
REQ-011 mem_ack  in  1  read completion; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  in  DATA_W  instruction word.
REQ-013 ins_valid  out  1  buffer head is valid toward the decoder.
REQ-014 ins_ready  in  1  decoder accepts the head.
REQ-015 ins_data  out  DATA_W  head instruction word.
REQ-016 ins_pc  out  ADDR_W  address of the head instruction.
REQ-017 fetch_err  out  1  sticky timeout flag; present only when the Configuration macro is defined.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and ADV.
REQ-019 IDLE->REQ SHALL occur when branch=0 and buffer count<2; on that edge mem_addr<=pc and mem_req<=1.
REQ-020 In REQ, mem_req and mem_addr SHALL hold until the mem_ack cycle; mem_req SHALL drop on the following edge.
REQ-021 When mem_ack arrives with no discard pending, the unit SHALL push {mem_addr, mem_rdata} and go REQ->ADV.
REQ-022 In ADV, pc_adv SHALL be 1 for exactly that cycle; the next state SHALL be IDLE. pc_adv SHALL be 0 in all other states.
REQ-023 Minimum issue interval SHALL be 3 cycles per instruction (IDLE, REQ, ADV) with zero-wait memory.
REQ-024 A zero-wait ack in the REQ cycle SHALL make ins_valid 1 in the next cycle (the ADV cycle) when the buffer was empty.
REQ-025 A pop SHALL occur when ins_valid&&ins_ready; the buffer is first-in first-out.
REQ-026 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-027 No push SHALL be possible when full, because issue requires count<2 and at most one request is outstanding.
REQ-028 branch=1 SHALL empty the buffer at that edge; ins_valid SHALL be 0 in the next cycle; any pop in that cycle SHALL be ignored.
REQ-029 branch in REQ without mem_ack SHALL set discard; the unit SHALL keep mem_req until ack, drop the data, skip ADV, return to IDLE, and clear discard.
REQ-030 branch in the same cycle as mem_ack SHALL drop the data, generate no pc_adv, and go to IDLE.
REQ-031 branch in ADV SHALL not suppress the pc_adv pulse already in progress. The PC counter gives preload precedence.
REQ-032 branch in IDLE SHALL block issue in that cycle; the new pc SHALL be sampled in the next IDLE cycle.

Reset
REQ-033 While res=1: state=IDLE, mem_req=0, mem_addr=0, pc_adv=0, ins_valid=0, ins_data=0, ins_pc=0, buffer count=0, discard=0, fetch_err=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request without waiting for mem_ack.

Configuration
REQ-035 Macro EV20_FETCH_TIMEOUT_EN defined: an 8-bit wait counter SHALL run in REQ. If 255 cycles pass without mem_ack, the unit SHALL set fetch_err (sticky until res), drop mem_req, and go to IDLE with no push and no pc_adv.
REQ-036 Macro EV20_FETCH_TIMEOUT_EN undefined: no counter and no fetch_err port; REQ SHALL wait indefinitely.

Structure
REQ-037 Package ev20_fetch_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and TIMEOUT_LIMIT=255.
REQ-038 Sub-module ev20_fetch_fifo (2-entry, count, push/pop/flush) SHALL hold the buffer; the FSM SHALL stay in ev20_fetch_unit.

Verification
REQ-039 Reset release, pc=0x000, zero-wait ack, ins_ready=1 -> mem_addr 0x000; ins_valid with ins_pc=0x000 in the cycle after ack; one pc_adv pulse; next mem_addr 0x001.
REQ-040 ins_ready=0, three fetch opportunities -> exactly 2 entries (0x000, 0x001); mem_req stays 0 while full; draining yields FIFO order.
REQ-041 branch during REQ with ack delayed 4 cycles, new pc=0x2A0 -> stale data never appears on ins_*; no pc_adv; next mem_addr=0x2A0.
REQ-042 branch coincident with mem_ack and with a pop -> buffer empty next cycle; no pc_adv; no double pop.
REQ-043 res pulsed while mem_req=1 -> all outputs 0 immediately (asynchronous); a late mem_ack after release is ignored.
REQ-044 EV20_FETCH_TIMEOUT_EN defined, mem_ack never asserted -> fetch_err=1 and mem_req=0 after 255 REQ cycles; fetching resumes at the current pc.
